// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction-fetch front end for the 5-stage MIPS pipeline.
// Issues sequential word fetches to instruction memory, buffers in-order
// responses in a small prefetch FIFO and presents {pc, instr} to decode.
// Taken-branch redirects flush the FIFO and discard wrong-path responses.
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance counters.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall_cyc
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic          run_q;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [CW:0]   occupancy;
    logic [31:0]   redirect_aligned;
    logic          req_fire;
    logic          rsp_accept;
    logic          rsp_drop;
    logic          rsp_push;
    logic          pop;

    // Request, response and pop qualifiers; run_q keeps the request port quiet while in reset
    always_comb begin
        occupancy        = {1'b0, count_q} + {1'b0, outstanding_q};
        redirect_aligned = redirect_pc & ~32'h3;
        imem_req_valid   = run_q && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
        imem_req_addr    = fetch_pc_q;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_accept       = imem_rsp_valid && (outstanding_q != '0);
        rsp_drop         = rsp_accept && (drop_cnt_q != '0);
        rsp_push         = rsp_accept && !rsp_drop && !redirect_valid;
        ifid_valid       = (count_q != '0);
        pop              = ifid_valid && !id_stall && !redirect_valid;
        ifid_instr       = ifid_valid ? instr_mem[rd_ptr_q] : 32'h0;
        ifid_pc          = ifid_valid ? pc_mem[rd_ptr_q] : 32'h0;
    end

    // Next-state: redirect flushes and re-arms both PCs, otherwise normal issue/response/pop
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(rsp_push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            run_q         <= 1'b1;
        end
    end

    // FIFO storage; contents are only observed through count_q, so no reset needed
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
            instr_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters for fetches, discarded responses and decode stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_dropped   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (req_fire && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (rsp_accept && !rsp_push && (perf_dropped != 32'hFFFF_FFFF)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (ifid_valid && id_stall && (perf_stall_cyc != 32'hFFFF_FFFF)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue with a simple
// in-order instruction memory model (1-cycle response latency, can be paused).
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall_cyc;
`endif

    int          total;
    int          bad;
    logic        rsp_enable;
    logic [31:0] exp_pc;
    logic [31:0] pend_q[$];
    logic [31:0] req_log[$];

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: accepts at posedge, answers in order on the following cycle
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend_q.push_back(imem_req_addr);
                req_log.push_back(imem_req_addr);
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (rsp_enable && (pend_q.size() > 0)) begin
                imem_rsp_data  = instr_of(pend_q.pop_front());
                imem_rsp_valid = 1'b1;
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_stall       = 1'b0;
        rsp_enable     = 1'b1;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid: got %b required 0", imem_req_valid); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_ifid_valid: got %b required 0", ifid_valid); end
        total++; if (ifid_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_ifid_instr: got %h required 0", ifid_instr); end
        total++; if (ifid_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_ifid_pc: got %h required 0", ifid_pc); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_req_addr: got %h required 0", imem_req_addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20 && !ifid_valid; i++) @(negedge clk);
        total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_start: got ifid_valid=%b required 1", ifid_valid); end
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_gap: got ifid_valid=%b required 1 at step %0d", ifid_valid, i); end
            total++; if (ifid_pc !== exp_pc) begin bad++; $display("[TB] FAIL stream_pc: got %h required %h", ifid_pc, exp_pc); end
            total++; if (ifid_instr !== instr_of(exp_pc)) begin bad++; $display("[TB] FAIL stream_instr: got %h required %h", ifid_instr, instr_of(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid: got %b required 1", ifid_valid); end
            total++; if (ifid_pc !== exp_pc) begin bad++; $display("[TB] FAIL stall_head_pc: got %h required %h", ifid_pc, exp_pc); end
            @(negedge clk);
        end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_req_stop: got %b required 0", imem_req_valid); end
        id_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_resume_valid: got %b required 1", ifid_valid); end
            total++; if (ifid_pc !== exp_pc) begin bad++; $display("[TB] FAIL stall_resume_pc: got %h required %h", ifid_pc, exp_pc); end
            total++; if (ifid_instr !== instr_of(exp_pc)) begin bad++; $display("[TB] FAIL stall_resume_instr: got %h required %h", ifid_instr, instr_of(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_req_valid: got %b required 0", imem_req_valid); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_ifid_valid: got %b required 0", ifid_valid); end
        total++; if (ifid_instr !== 32'h0) begin bad++; $display("[TB] FAIL areset_ifid_instr: got %h required 0", ifid_instr); end
        total++; if (ifid_pc !== 32'h0) begin bad++; $display("[TB] FAIL areset_ifid_pc: got %h required 0", ifid_pc); end
        req_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && req_log.size() == 0; i++) @(negedge clk);
        total++;
        if (req_log.size() == 0) begin
            bad++; $display("[TB] FAIL areset_first_fetch: got no request required %h", 32'h0);
        end else if (req_log[0] !== 32'h0) begin
            bad++; $display("[TB] FAIL areset_first_fetch: got %h required %h", req_log[0], 32'h0);
        end
    endtask

    task automatic test_ready_low();
        for (int i = 0; i < 20 && !(imem_req_valid && imem_req_addr == 32'h10); i++) @(negedge clk);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL ready_low_valid: got %b required 1", imem_req_valid); end
            total++; if (imem_req_addr !== 32'h10) begin bad++; $display("[TB] FAIL ready_low_addr: got %h required %h", imem_req_addr, 32'h10); end
            @(negedge clk);
        end
        req_log.delete();
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (req_log.size() < 2) begin
            bad++; $display("[TB] FAIL ready_resume_count: got %0d required 2", req_log.size());
        end else begin
            if (req_log[0] !== 32'h10) begin bad++; $display("[TB] FAIL ready_resume_addr0: got %h required %h", req_log[0], 32'h10); end
            total++;
            if (req_log[1] !== 32'h14) begin bad++; $display("[TB] FAIL ready_resume_addr1: got %h required %h", req_log[1], 32'h14); end
        end
    endtask

    task automatic test_redirect();
        imem_req_ready = 1'b0;
        repeat (4) @(negedge clk);
        rsp_enable     = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        total++; if (pend_q.size() != 2) begin bad++; $display("[TB] FAIL redirect_inflight: got %0d required 2", pend_q.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        imem_req_ready = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL redirect_no_issue: got %b required 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        rsp_enable     = 1'b1;
        for (int i = 0; i < 20 && !ifid_valid; i++) @(negedge clk);
        exp_pc = 32'h40;
        for (int i = 0; i < 2; i++) begin
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL redirect_valid: got %b required 1", ifid_valid); end
            total++; if (ifid_pc !== exp_pc) begin bad++; $display("[TB] FAIL redirect_pc: got %h required %h", ifid_pc, exp_pc); end
            total++; if (ifid_instr !== instr_of(exp_pc)) begin bad++; $display("[TB] FAIL redirect_instr: got %h required %h", ifid_instr, instr_of(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        req_log.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !ifid_valid; i++) @(negedge clk);
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_valid: got %b required 1", ifid_valid); end
            total++; if (ifid_pc !== exp_pc) begin bad++; $display("[TB] FAIL wrap_pc: got %h required %h", ifid_pc, exp_pc); end
            total++; if (ifid_instr !== instr_of(exp_pc)) begin bad++; $display("[TB] FAIL wrap_instr: got %h required %h", ifid_instr, instr_of(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
        exp_pc = 32'hFFFF_FFF8;
        total++;
        if (req_log.size() < 3) begin
            bad++; $display("[TB] FAIL wrap_req_count: got %0d required 3", req_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i > 0) total++;
                if (req_log[i] !== exp_pc) begin bad++; $display("[TB] FAIL wrap_req_addr%0d: got %h required %h", i, req_log[i], exp_pc); end
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_stall();
        test_async_reset();
        test_ready_low();
        test_redirect();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
